// File: rtl/term_input_decoder_pkg.sv
// Shared key codes, ASCII constants, FSM encoding and byte-class helpers
// for the terminal input decoder.
package term_input_decoder_pkg;

    typedef enum logic [2:0] {
        KEY_CHAR  = 3'd0,
        KEY_UP    = 3'd1,
        KEY_DOWN  = 3'd2,
        KEY_RIGHT = 3'd3,
        KEY_LEFT  = 3'd4,
        KEY_ESC   = 3'd5,
        KEY_ENTER = 3'd6
    } key_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI_P1 = 2'd2,
        ST_CSI_P2 = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_SPACE    = 8'd32;
    localparam logic [7:0] ASCII_ESC      = 8'd27;
    localparam logic [7:0] ASCII_LBRACKET = 8'd91;
    localparam logic [7:0] ASCII_SEMI     = 8'd59;
    localparam logic [7:0] ASCII_CR       = 8'd13;
    localparam logic [7:0] ASCII_LF       = 8'd10;
    localparam logic [7:0] ASCII_TILDE    = 8'h7E;
    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [7:0] ASCII_NINE     = 8'h39;
    localparam logic [7:0] ASCII_AT       = 8'h40;
    localparam logic [7:0] ASCII_UC_A     = 8'h41;
    localparam logic [7:0] ASCII_UC_D     = 8'h44;
    localparam logic [7:0] ASCII_UC_R     = 8'h52;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_SPACE) && (b <= ASCII_TILDE);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic is_arrow(input logic [7:0] b);
        return (b >= ASCII_UC_A) && (b <= ASCII_UC_D);
    endfunction

endpackage

// File: rtl/term_input_decoder_csi_param_acc.sv
// Saturating decimal accumulator for one CSI numeric parameter.
module csi_param_acc
    import term_input_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dig_en,
    input  logic [3:0] dig,
    output logic [7:0] value
);

    logic [7:0]  value_q;
    logic [7:0]  value_d;
    logic [11:0] next_s;

    // value*10 + digit at 12 bits, clamped to 255
    always_comb begin
        next_s  = ({4'd0, value_q} * 12'd10) + {8'd0, dig};
        value_d = value_q;
        if (clr) begin
            value_d = 8'd0;
        end else if (dig_en) begin
            value_d = (next_s > 12'd255) ? 8'd255 : next_s[7:0];
        end else begin
            value_d = value_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 8'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/term_input_decoder.sv
// Terminal input byte-stream decoder: printable keys, Enter, lone ESC by
// timeout, CSI arrows and the ESC [ row ; col R cursor-position report.
module term_input_decoder
    import term_input_decoder_pkg::*;
#(
    parameter int ESC_TIMEOUT = 4,
    parameter int DEF_ROW     = 24,
    parameter int DEF_COL     = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       key_valid,
    output logic [2:0] key_code,
    output logic [7:0] key_char,
    output logic       size_valid,
    output logic [7:0] n_row,
    output logic [7:0] n_col,
    output logic       err
);

    localparam int TW = $clog2(ESC_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);

    state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic      key_valid_q, key_valid_d;
    key_code_e key_code_q, key_code_d;
    logic [7:0] key_char_q, key_char_d;
    logic      size_valid_q, size_valid_d;
    logic [7:0] n_row_q, n_row_d;
    logic [7:0] n_col_q, n_col_d;
    logic      err_q, err_d;

    logic       p_clr_s;
    logic       p1_dig_en_s;
    logic       p2_dig_en_s;
    logic [7:0] p1_s;
    logic [7:0] p2_s;
    logic       in_p2_s;
    logic       timeout_s;

    csi_param_acc u_p1 (
        .clk    (clk),
        .rst    (rst),
        .clr    (p_clr_s),
        .dig_en (p1_dig_en_s),
        .dig    (in_data[3:0]),
        .value  (p1_s)
    );

    csi_param_acc u_p2 (
        .clk    (clk),
        .rst    (rst),
        .clr    (p_clr_s),
        .dig_en (p2_dig_en_s),
        .dig    (in_data[3:0]),
        .value  (p2_s)
    );

    assign in_p2_s   = (state_q == ST_CSI_P2);
    assign timeout_s = !in_valid && (timer_q == TIMER_LAST);

    // Next-state, timer and event decode for one consumed byte or idle cycle
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        key_valid_d  = 1'b0;
        size_valid_d = 1'b0;
        err_d        = 1'b0;
        key_code_d   = key_code_q;
        key_char_d   = key_char_q;
        n_row_d      = n_row_q;
        n_col_d      = n_col_q;
        p_clr_s      = 1'b0;
        p1_dig_en_s  = 1'b0;
        p2_dig_en_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!in_valid) begin
                    state_d = ST_IDLE;
                end else if (is_printable(in_data)) begin
                    key_valid_d = 1'b1;
                    key_code_d  = KEY_CHAR;
                    key_char_d  = in_data;
                end else if ((in_data == ASCII_CR) || (in_data == ASCII_LF)) begin
                    key_valid_d = 1'b1;
                    key_code_d  = KEY_ENTER;
                    key_char_d  = 8'd0;
                end else if (in_data == ASCII_ESC) begin
                    state_d = ST_ESC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ESC: begin
                if (in_valid) begin
                    timer_d = '0;
                    if (in_data == ASCII_LBRACKET) begin
                        state_d = ST_CSI_P1;
                        p_clr_s = 1'b1;
                    end else if (in_data == ASCII_ESC) begin
                        key_valid_d = 1'b1;
                        key_code_d  = KEY_ESC;
                        key_char_d  = 8'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    timer_d     = '0;
                    key_valid_d = 1'b1;
                    key_code_d  = KEY_ESC;
                    key_char_d  = 8'd0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end

            ST_CSI_P1, ST_CSI_P2: begin
                if (in_valid) begin
                    timer_d = '0;
                    if (is_digit(in_data)) begin
                        p1_dig_en_s = !in_p2_s;
                        p2_dig_en_s = in_p2_s;
                    end else if (in_data == ASCII_SEMI) begin
                        err_d   = in_p2_s;
                        state_d = in_p2_s ? ST_IDLE : ST_CSI_P2;
                    end else if (is_arrow(in_data) && !in_p2_s) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_code_e'(in_data[2:0]);
                        key_char_d  = 8'd0;
                        state_d     = ST_IDLE;
                    end else if ((in_data == ASCII_UC_R) && in_p2_s) begin
                        size_valid_d = 1'b1;
                        n_row_d      = p1_s;
                        n_col_d      = p2_s;
                        state_d      = ST_IDLE;
                    end else if (in_data == ASCII_ESC) begin
                        // ESC aborts the sequence but also starts a new one
                        err_d   = 1'b1;
                        state_d = ST_ESC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end

            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, timer and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= KEY_CHAR;
            key_char_q   <= 8'd0;
            size_valid_q <= 1'b0;
            n_row_q      <= 8'(DEF_ROW);
            n_col_q      <= 8'(DEF_COL);
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_char_q   <= key_char_d;
            size_valid_q <= size_valid_d;
            n_row_q      <= n_row_d;
            n_col_q      <= n_col_d;
            err_q        <= err_d;
        end
    end

    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_char   = key_char_q;
    assign size_valid = size_valid_q;
    assign n_row      = n_row_q;
    assign n_col      = n_col_q;
    assign err        = err_q;

endmodule

// File: doc/term_input_decoder.md
# term_input_decoder

Byte-stream decoder for terminal input: it sits between `io` and `controller` and turns raw stdin bytes into key events and terminal-size reports. It parses plain printable keys, Enter, a lone ESC (by timeout), CSI arrow keys (`ESC [ A..D`), and the cursor-position report `ESC [ row ; col R`. The cursor-position report is the inbound counterpart of the `ESC [ row ; col H` cursor moves the view emits. It replaces the `$fscanf` size read and the raw `inp == SPACE` compares with registered, one-cycle event pulses.

## Interface
- `ESC_TIMEOUT`, default 4: idle cycles after ESC before a lone ESC key is emitted (≥1).
- `DEF_ROW`, default 24: reset value of `n_row`.
- `DEF_COL`, default 80: reset value of `n_col`.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds a byte this cycle.
- `in_data`  in  8  input byte; there is no backpressure, and a byte is consumed in every cycle where `in_valid` is high.
- `key_valid`  out  1  one-cycle key event pulse.
- `key_code`  out  3  0=CHAR, 1=UP, 2=DOWN, 3=RIGHT, 4=LEFT, 5=ESC, 6=ENTER; held between pulses.
- `key_char`  out  8  byte for CHAR events, 0 for all other events; held.
- `size_valid`  out  1  one-cycle pulse when `n_row`/`n_col` update.
- `n_row`  out  8  last reported row count.
- `n_col`  out  8  last reported column count.
- `err`  out  1  one-cycle pulse on a malformed or unsupported sequence.

## Operation
- **Reset values:** state IDLE, timer 0, parameters 0, `key_valid`/`size_valid`/`err` 0, `key_code` 0, `key_char` 0, `n_row`=`DEF_ROW`, `n_col`=`DEF_COL`.
- **FSM states:** IDLE, ESC, CSI_P1, CSI_P2.
- **IDLE:**
  - 0x20–0x7E: CHAR event, `key_char`=byte.
  - 0x0A or 0x0D: ENTER.
  - 0x1B: go to ESC and clear the timer.
  - Any other byte: silently dropped.
- **ESC:**
  - `[` (0x5B): go to CSI_P1, with p1=p2=0 and the semicolon flag cleared.
  - 0x1B: emit ESC, stay in ESC, restart the timer.
  - Any other byte: `err`, go to IDLE; the byte is dropped.
  - Timeout: emit ESC, go to IDLE.
- **CSI_P1 / CSI_P2, byte handling:**
  - Digit `0`–`9`: p = p×10 + d, computed at 12 bits and saturated to 255.
  - `;` in P1: go to P2.
  - `;` in P2: `err`, go to IDLE.
  - `A`/`B`/`C`/`D`: UP/DOWN/RIGHT/LEFT, accepted only with no `;` seen; parameters are ignored, go to IDLE. After a `;`, these bytes give `err` instead.
  - `R` in P2: `n_row`←p1, `n_col`←p2, `size_valid`, go to IDLE. `R` in P1 gives `err`.
  - Any other byte in 0x40–0x7E: `err`, go to IDLE.
  - Byte outside 0x20–0x7E other than ESC: `err`, go to IDLE.
  - 0x1B: `err`, go to ESC with the timer cleared.
- **CSI_P1 / CSI_P2, timeout:** `err`, go to IDLE.
- **Report values:** `R` with a zero parameter is still applied as reported; clamping is the consumer's job.
- **Output exclusivity:** at most one of `key_valid`/`size_valid`/`err` is high in any cycle.
- **Reset mid-sequence:** partial state is discarded and no event is emitted.

## Timing
- All outputs are registered. A byte sampled at edge t produces its event pulse during the cycle after edge t, high for exactly one cycle.
- **Timer:** counts cycles with `in_valid` low while in ESC/CSI, and clears on every accepted byte.
- **Timeout:** ESC sampled in cycle t, then no byte in cycles t+1 … t+`ESC_TIMEOUT`, gives `key_valid` (ESC) in cycle t+`ESC_TIMEOUT`+1.
- **Timeout boundary:** a byte arriving in cycle t+`ESC_TIMEOUT` still continues the sequence.
- **Back-to-back bytes:** bytes every cycle are fully supported, and consecutive events may pulse in consecutive cycles.
- **Held outputs:** `n_row`/`n_col`/`key_code`/`key_char` change only with their pulse.

## Structure
- **Shared include (defines):**
  - Key codes KEY_CHAR … KEY_ENTER.
  - ASCII constants: SPACE 32, ESC 27, LBRACKET 91, SEMI 59, CR 13, LF 10.
  - The FSM state encoding.
- **Sub-module:** `csi_param_acc` holds the saturating decimal accumulator (clear, digit strobe, 4-bit digit, 8-bit value). It is instantiated twice, for p1 and p2.
- **Top level:** FSM, timer (width $clog2(`ESC_TIMEOUT`+1)), and output registers.

## Test plan
- Reset, then bytes `a`, 0x20, 0x0D on consecutive cycles → CHAR 0x61, CHAR 0x20, ENTER on three consecutive cycles; `n_row`=24, `n_col`=80 throughout.
- `ESC [ A` then `ESC [ 1 ; 5 D` → UP; then `err` on the `D` (a `;` was seen), with no LEFT emitted.
- `ESC [ 4 0 ; 1 2 0 R` → `size_valid` one cycle after `R`, `n_row`=40, `n_col`=120; `ESC [ 9 9 9 ; 3 R` → `n_row`=255, `n_col`=3.
- Lone ESC with `ESC_TIMEOUT`=4 and no further bytes → ESC key exactly 5 cycles after the ESC cycle. ESC, idle 3 cycles, then `[` `B` → DOWN and no ESC event.
- `ESC x` → `err`, state back to IDLE; next byte `q` → CHAR 0x71. `ESC [ 5 ESC [ C` → `err` then RIGHT.
- `rst` asserted after `ESC [ 3` → no pulse; after release, `;1R` gives CHAR 0x3B, CHAR 0x31, CHAR 0x52 with `n_row`/`n_col` unchanged.
